// File: rtl/padframe_pkg.sv
// Shared definitions for the padframe configuration chain: per-pad control bit
// layout, reset configuration, self-test FSM states and loopback patterns.
package padframe_pkg;

    localparam int CFG_BITS  = 8;
    localparam int CFG_OE    = 0;
    localparam int CFG_IE    = 1;
    localparam int CFG_PU    = 2;
    localparam int CFG_PD    = 3;
    localparam int CFG_PDRV0 = 4;
    localparam int CFG_PDRV1 = 5;
    localparam int CFG_CS    = 6;
    localparam int CFG_SL    = 7;

    // Pads come out of reset as plain inputs.
    localparam logic [CFG_BITS-1:0] CFG_RESET = 8'b0000_0010;

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_e;

    // Loopback pattern bit for pad n in the given phase.
    function automatic logic alt_pattern(input logic [1:0] phase, input int unsigned n);
        logic even;
        even = ((n % 2) == 0);
        case (phase)
            2'd0:    return 1'b1;
            2'd1:    return 1'b0;
            2'd2:    return even;
            default: return ~even;
        endcase
    endfunction

endpackage

// File: rtl/padframe_cfg_slice.sv
// One pad's segment of the configuration chain: a shadow shift register that
// feeds the next pad, plus the active register the pad controls come from.
module padframe_cfg_slice
    import padframe_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sdi,
    input  logic                shift,
    input  logic                load,
    output logic                sdo,
    output logic [CFG_BITS-1:0] active
);

    logic [CFG_BITS-1:0] shadow;

    // Load samples the pre-shift shadow when both strobes coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= CFG_RESET;
            active <= CFG_RESET;
        end else begin
            if (shift) shadow <= {shadow[CFG_BITS-2:0], sdi};
            if (load)  active <= shadow;
        end
    end

    assign sdo = shadow[CFG_BITS-1];

endmodule

// File: rtl/padframe_cfg_chain.sv
// Padframe controller: serial shadow chain with atomic apply, and a four-phase
// loopback self-test that overrides pad direction while it runs.
module padframe_cfg_chain
    import padframe_pkg::*;
#(
    parameter int NUM_PADS      = 46,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_sdi,
    input  logic                cfg_shift,
    input  logic                cfg_load,
    output logic                cfg_sdo,
    input  logic                test_start,
    output logic                test_busy,
    output logic                test_done,
    output logic [NUM_PADS-1:0] test_fail,
    input  logic [NUM_PADS-1:0] core_A,
    output logic [NUM_PADS-1:0] core_Y,
    output logic [NUM_PADS-1:0] bidir_OE,
    output logic [NUM_PADS-1:0] bidir_IE,
    output logic [NUM_PADS-1:0] bidir_PU,
    output logic [NUM_PADS-1:0] bidir_PD,
    output logic [NUM_PADS-1:0] bidir_PDRV0,
    output logic [NUM_PADS-1:0] bidir_PDRV1,
    output logic [NUM_PADS-1:0] bidir_CS,
    output logic [NUM_PADS-1:0] bidir_SL,
    output logic [NUM_PADS-1:0] bidir_A,
    input  logic [NUM_PADS-1:0] bidir_Y
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    logic [NUM_PADS:0]                    chain;
    logic [NUM_PADS-1:0][CFG_BITS-1:0]    act;
    state_e                               state;
    logic [1:0]                           phase;
    logic [CW-1:0]                        cnt;
    logic [NUM_PADS-1:0]                  pat_q;
    logic [NUM_PADS-1:0]                  pat_next;

    assign chain[0] = cfg_sdi;
    assign cfg_sdo  = chain[NUM_PADS];

    for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
        padframe_cfg_slice u_slice (
            .clk    (clk),
            .rst_n  (rst_n),
            .sdi    (chain[i]),
            .shift  (cfg_shift),
            .load   (cfg_load),
            .sdo    (chain[i+1]),
            .active (act[i])
        );

        // Test forces pads to drive-and-receive with no pulls.
        assign bidir_OE[i]    = act[i][CFG_OE] | test_busy;
        assign bidir_IE[i]    = act[i][CFG_IE] | test_busy;
        assign bidir_PU[i]    = act[i][CFG_PU] & ~test_busy;
        assign bidir_PD[i]    = act[i][CFG_PD] & ~test_busy;
        assign bidir_PDRV0[i] = act[i][CFG_PDRV0];
        assign bidir_PDRV1[i] = act[i][CFG_PDRV1];
        assign bidir_CS[i]    = act[i][CFG_CS];
        assign bidir_SL[i]    = act[i][CFG_SL];
    end

    assign bidir_A = test_busy ? pat_q : core_A;
    assign core_Y  = test_busy ? '0 : bidir_Y;

    always_comb begin
        pat_next = '0;
        for (int i = 0; i < NUM_PADS; i++) pat_next[i] = alt_pattern(phase, i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase     <= 2'd0;
            cnt       <= '0;
            pat_q     <= '0;
            test_busy <= 1'b0;
            test_done <= 1'b0;
            test_fail <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (test_start) begin
                        state     <= DRIVE;
                        phase     <= 2'd0;
                        test_fail <= '0;
                        test_busy <= 1'b1;
                    end
                end
                DRIVE: begin
                    pat_q <= pat_next;
                    cnt   <= CW'(SETTLE_CYCLES - 1);
                    state <= SETTLE;
                end
                SETTLE: begin
                    if (cnt == '0) state <= CHECK;
                    else           cnt   <= cnt - 1'b1;
                end
                CHECK: begin
                    test_fail <= test_fail | (bidir_Y ^ pat_q);
                    if (phase == 2'd3) begin
                        state     <= DONE;
                        test_done <= 1'b1;
                        test_busy <= 1'b0;
                    end else begin
                        phase <= phase + 2'd1;
                        state <= DRIVE;
                    end
                end
                DONE: begin
                    test_done <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_padframe_cfg_chain.sv
// Scoreboard bench for padframe_cfg_chain: stimulus queues expected values,
// a negedge monitor compares them and checks every test_done pulse.
module tb_padframe_cfg_chain;
    import padframe_pkg::*;

    localparam int N = 46;
    localparam int S = 4;
    localparam int L = N * CFG_BITS;
    localparam logic [63:0] ALL1 = (64'd1 << N) - 64'd1;
    localparam logic [63:0] P45  = 64'd1 << 45;
    localparam int TEST_LEN = 4 * (S + 2);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cfg_sdi = 1'b0, cfg_shift = 1'b0, cfg_load = 1'b0, test_start = 1'b0;
    logic cfg_sdo, test_busy, test_done;
    logic [N-1:0] test_fail, core_A, core_Y, bidir_A, bidir_Y;
    logic [N-1:0] bidir_OE, bidir_IE, bidir_PU, bidir_PD, bidir_PDRV0, bidir_PDRV1, bidir_CS, bidir_SL;
    logic [1:0] fault = 2'd0;

    padframe_cfg_chain #(.NUM_PADS(N), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_sdi(cfg_sdi), .cfg_shift(cfg_shift), .cfg_load(cfg_load),
        .cfg_sdo(cfg_sdo), .test_start(test_start), .test_busy(test_busy), .test_done(test_done),
        .test_fail(test_fail), .core_A(core_A), .core_Y(core_Y),
        .bidir_OE(bidir_OE), .bidir_IE(bidir_IE), .bidir_PU(bidir_PU), .bidir_PD(bidir_PD),
        .bidir_PDRV0(bidir_PDRV0), .bidir_PDRV1(bidir_PDRV1), .bidir_CS(bidir_CS), .bidir_SL(bidir_SL),
        .bidir_A(bidir_A), .bidir_Y(bidir_Y)
    );

    always #5 clk = ~clk;

    // Pad loopback with optional injected defects.
    always_comb begin
        bidir_Y = bidir_A;
        if (fault == 2'd1) bidir_Y[7] = 1'b0;
        if (fault == 2'd2) bidir_Y[13] = bidir_A[12];
    end

    typedef enum int {S_OE, S_IE, S_PU, S_PD, S_PDRV0, S_PDRV1, S_CS, S_SL,
                      S_FAIL, S_SDO, S_BUSY, S_COREY, S_A} sel_e;
    typedef struct { string name; sel_e sel; logic [63:0] exp; } chk_t;
    typedef struct { int len; logic [63:0] mask; } done_t;

    chk_t  chk_q[$];
    done_t done_q[$];
    int errors = 0;
    int checks = 0;
    int busy_cnt = 0;

    function automatic logic [63:0] sample(sel_e s);
        case (s)
            S_OE:    return 64'(bidir_OE);
            S_IE:    return 64'(bidir_IE);
            S_PU:    return 64'(bidir_PU);
            S_PD:    return 64'(bidir_PD);
            S_PDRV0: return 64'(bidir_PDRV0);
            S_PDRV1: return 64'(bidir_PDRV1);
            S_CS:    return 64'(bidir_CS);
            S_SL:    return 64'(bidir_SL);
            S_FAIL:  return 64'(test_fail);
            S_SDO:   return 64'(cfg_sdo);
            S_BUSY:  return 64'(test_busy);
            S_COREY: return 64'(core_Y);
            default: return 64'(bidir_A);
        endcase
    endfunction

    task automatic expect_sig(input string n, input sel_e s, input logic [63:0] e);
        chk_t c;
        c.name = n; c.sel = s; c.exp = e;
        chk_q.push_back(c);
    endtask

    task automatic expect_done(input int len, input logic [63:0] mask);
        done_t d;
        d.len = len; d.mask = mask;
        done_q.push_back(d);
    endtask

    // Monitor: drains queued checks and scores every completion pulse.
    always @(negedge clk) begin
        chk_t  c;
        done_t d;
        logic [63:0] got;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            got = sample(c.sel);
            checks++;
            if (got !== c.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", c.name, got, c.exp);
            end
        end
        if (!rst_n) busy_cnt = 0;
        else begin
            if (test_busy) busy_cnt++;
            if (test_done) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got test_done=1 expected none");
                end else begin
                    d = done_q.pop_front();
                    if (busy_cnt != d.len) begin
                        errors++;
                        $display("FAIL busy_len: got %0d expected %0d", busy_cnt, d.len);
                    end
                    checks++;
                    if (64'(test_fail) !== d.mask) begin
                        errors++;
                        $display("FAIL done_fail_mask: got %h expected %h", test_fail, d.mask);
                    end
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_test();
        test_start = 1'b1;
        tick();
        test_start = 1'b0;
    endtask

    task automatic wait_done(input string n);
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (test_done) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no test_done expected one within 200 cycles", n);
        end
        tick();
    endtask

    task automatic shift_zeros();
        cfg_sdi = 1'b0;
        cfg_shift = 1'b1;
        repeat (L) tick();
        cfg_shift = 1'b0;
    endtask

    task automatic expect_reset_vals(input string n);
        expect_sig({n, "_oe"}, S_OE, 64'd0);
        expect_sig({n, "_ie"}, S_IE, ALL1);
        expect_sig({n, "_fail"}, S_FAIL, 64'd0);
        expect_sig({n, "_sdo"}, S_SDO, 64'd0);
        expect_sig({n, "_busy"}, S_BUSY, 64'd0);
    endtask

    logic [L-1:0] stream;
    logic [7:0]   cfgv;

    initial begin
        core_A = 46'h1234_5678_9ABC;
        for (int p = 0; p < N; p++) begin
            cfgv = (p == 45) ? 8'hA5 : 8'h01;
            for (int b = 0; b < 8; b++) stream[(N - 1 - p) * 8 + (7 - b)] = cfgv[b];
        end

        // Reset state, then reset asserted part-way through a shift.
        tick(); tick();
        expect_reset_vals("reset");
        tick();
        rst_n = 1'b1;
        tick();
        expect_reset_vals("post_reset");
        expect_sig("normal_core_y", S_COREY, 64'(core_A));
        expect_sig("normal_a", S_A, 64'(core_A));
        cfg_sdi = 1'b1;
        cfg_shift = 1'b1;
        repeat (20) tick();
        rst_n = 1'b0;
        cfg_shift = 1'b0;
        tick();
        expect_reset_vals("midshift_reset");
        tick();
        rst_n = 1'b1;
        tick();

        // Full chain load: pad 45 = A5, others = 01.
        cfg_shift = 1'b1;
        for (int k = 0; k < L; k++) begin
            cfg_sdi = stream[k];
            tick();
        end
        cfg_shift = 1'b0;
        expect_sig("preload_oe", S_OE, 64'd0);
        tick();
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        expect_sig("load_oe", S_OE, ALL1);
        expect_sig("load_ie", S_IE, 64'd0);
        expect_sig("load_pu", S_PU, P45);
        expect_sig("load_pdrv1", S_PDRV1, P45);
        expect_sig("load_pdrv0", S_PDRV0, 64'd0);
        expect_sig("load_sl", S_SL, P45);
        expect_sig("load_cs", S_CS, 64'd0);
        tick();

        // Replay the stream out of cfg_sdo.
        cfg_sdi = 1'b0;
        cfg_shift = 1'b1;
        for (int k = 0; k < L; k++) begin
            expect_sig("sdo_replay", S_SDO, 64'(stream[k]));
            tick();
        end
        cfg_shift = 1'b0;

        // Clean loopback.
        expect_done(TEST_LEN, 64'd0);
        start_test();
        tick(); tick();
        expect_sig("test_busy", S_BUSY, 64'd1);
        expect_sig("test_a_ones", S_A, ALL1);
        expect_sig("test_oe", S_OE, ALL1);
        expect_sig("test_ie", S_IE, ALL1);
        expect_sig("test_pu_off", S_PU, 64'd0);
        expect_sig("test_pdrv1", S_PDRV1, P45);
        expect_sig("test_core_y", S_COREY, 64'd0);
        wait_done("clean");
        expect_sig("post_oe", S_OE, ALL1);
        expect_sig("post_pu", S_PU, P45);
        expect_sig("post_core_y", S_COREY, 64'(core_A));
        tick();

        // Pad 7 stuck at 0; the flag must persist after completion.
        fault = 2'd1;
        expect_done(TEST_LEN, 64'd1 << 7);
        start_test();
        wait_done("stuck7");
        repeat (3) tick();
        expect_sig("fail_sticky", S_FAIL, 64'd1 << 7);
        tick();

        // Pad 13 reads pad 12's output; new test clears the old flag.
        fault = 2'd2;
        expect_done(TEST_LEN, 64'd1 << 13);
        start_test();
        wait_done("short13");
        tick();

        // Retrigger during busy cycle 5 is ignored.
        fault = 2'd0;
        expect_done(TEST_LEN, 64'd0);
        start_test();
        repeat (4) tick();
        test_start = 1'b1;
        tick();
        test_start = 1'b0;
        wait_done("retrigger");
        repeat (3) tick();

        // Reset at busy cycle 10 with a stuck pad already flagged.
        fault = 2'd1;
        start_test();
        repeat (8) tick();
        expect_sig("pre_reset_fail", S_FAIL, 64'd1 << 7);
        tick();
        rst_n = 1'b0;
        expect_sig("midtest_reset_busy", S_BUSY, 64'd0);
        expect_sig("midtest_reset_fail", S_FAIL, 64'd0);
        expect_sig("midtest_reset_oe", S_OE, 64'd0);
        expect_sig("midtest_reset_ie", S_IE, ALL1);
        tick();
        rst_n = 1'b1;
        fault = 2'd0;
        tick();

        // Load of an all-zero shadow during a test takes effect after it.
        shift_zeros();
        expect_done(TEST_LEN, 64'd0);
        start_test();
        repeat (3) tick();
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        expect_sig("midload_oe_held", S_OE, ALL1);
        expect_sig("midload_ie_held", S_IE, ALL1);
        wait_done("midload");
        expect_sig("midload_after_oe", S_OE, 64'd0);
        expect_sig("midload_after_ie", S_IE, 64'd0);
        repeat (3) tick();

        checks++;
        if (done_q.size() != 0) begin
            errors++;
            $display("FAIL done_queue: got %0d pending expected 0", done_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
